video_text_fetch: RTL and testbench

- Read side of the text display memory; the test writer and the CPU path fill the same memory.
- Walks display memory in raster order and fetches one cell word per 8-pixel character.
- Looks up the glyph row in the font ROM and serializes it to a 4-bit color index per pixel.
- Sits between the display RAM / font ROM read ports and the palette/DAC stage; it is driven by the video timing generator.

---
 rtl/video_text_fetch_pkg.sv | 38 +++
 rtl/video_glyph_shift.sv | 48 ++++
 rtl/video_text_fetch.sv | 212 +++++++++++++++++++++
 tb/tb_video_text_fetch.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/video_text_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : video_text_fetch_pkg
// Brief    : Shared types and field positions for the text-mode fetch path.
// Revision : 1.0 - initial release
// ============================================================================
package video_text_fetch_pkg;

    // Default text geometry
    localparam int TEXT_COLS   = 80;
    localparam int TEXT_ROWS   = 30;

    // Memory and pixel widths
    localparam int DISP_ADDR_W = $clog2(TEXT_COLS * TEXT_ROWS);
    localparam int DISP_DATA_W = 16;
    localparam int COLOR_W     = 4;
    localparam int CHAR_BITS   = 8;
    localparam int GLYPH_W     = 8;
    localparam int FONT_ADDR_W = 12;

    // Cell word layout: [15:12] back, [11:8] fore, [7:0] char
    localparam int BACK_LSB    = 12;
    localparam int FORE_LSB    = 8;
    localparam int CHAR_LSB    = 0;

    typedef logic [DISP_ADDR_W-1:0] disp_addr_t;
    typedef logic [DISP_DATA_W-1:0] disp_data_t;
    typedef logic [COLOR_W-1:0]     color_t;

    typedef enum logic [1:0] {
        F_IDLE    = 2'd0,
        F_RD_CELL = 2'd1,
        F_RD_FONT = 2'd2,
        F_LATCH   = 2'd3
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/video_glyph_shift.sv
`default_nettype none
// ============================================================================
// Module   : video_glyph_shift
// Brief    : Glyph row load/shift register with fore/back select; registered
//            color output. The first pixel of a row is selected straight from
//            the load value so the output trails the cell boundary by 1 cycle.
// Revision : 1.0 - initial release
// ============================================================================
module video_glyph_shift
    import video_text_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               blank,
    input  logic               load,
    input  logic [GLYPH_W-1:0] load_bits,
    input  color_t             load_fore,
    input  color_t             load_back,
    output color_t             color
);

    logic [GLYPH_W-1:0] shift_bits;
    color_t             fore;
    color_t             back;
    color_t             color_q;

    // Load a glyph row on a cell boundary, otherwise emit one pixel per clock.
    always_ff @(posedge clk) begin
        if (reset || blank) begin
            shift_bits <= '0;
            fore       <= '0;
            back       <= '0;
            color_q    <= '0;
        end else if (load) begin
            shift_bits <= {load_bits[GLYPH_W-2:0], 1'b0};
            fore       <= load_fore;
            back       <= load_back;
            color_q    <= load_bits[GLYPH_W-1] ? load_fore : load_back;
        end else begin
            shift_bits <= {shift_bits[GLYPH_W-2:0], 1'b0};
            color_q    <= shift_bits[GLYPH_W-1] ? fore : back;
        end
    end

    assign color = color_q;

endmodule
`default_nettype wire

// File: rtl/video_text_fetch.sv
`default_nettype none
// ============================================================================
// Module   : video_text_fetch
// Brief    : Text-mode read path. Walks display memory in raster order, fetches
//            one cell word and one glyph row per 8-pixel character, and feeds
//            the glyph shifter that produces a 4-bit color index per pixel.
// Revision : 1.0 - initial release
// ============================================================================
module video_text_fetch
    import video_text_fetch_pkg::*;
#(
    parameter int COLS   = TEXT_COLS,
    parameter int ROWS   = TEXT_ROWS,
    parameter int FONT_H = 16,
    parameter int CHAR_W = GLYPH_W
) (
    input  logic                   clk,
    input  logic                   reset_i,
    input  logic                   eof_i,
    input  logic                   sol_i,
    input  logic                   vis_i,
    output logic                   rd_en_o,
    output disp_addr_t             rd_addr_o,
    input  disp_data_t             rd_data_i,
    output logic [FONT_ADDR_W-1:0] font_addr_o,
    input  logic [GLYPH_W-1:0]     font_data_i,
    output color_t                 color_o,
    output logic                   pix_valid_o
);

    localparam int              SL_W    = $clog2(FONT_H);
    localparam int              PX_W    = $clog2(CHAR_W);
    localparam logic [SL_W-1:0] SL_LAST = SL_W'(FONT_H - 1);
    localparam logic [PX_W-1:0] PX_LAST = PX_W'(CHAR_W - 1);
    // Column and row counters are 8 bits; they saturate rather than wrap.
    localparam logic [7:0]      COL_END = 8'(COLS);
    localparam logic [7:0]      ROW_END = 8'(ROWS);

    fetch_state_t           state;
    fetch_state_t           state_next;

    logic [SL_W-1:0]        scanline;
    logic [7:0]             text_row;
    disp_addr_t             line_base;
    logic [7:0]             col;
    logic [PX_W-1:0]        px;
    logic                   vis_prev;
    logic                   frame_armed;
    logic                   line_armed;
    logic                   pix_valid;

    logic                   fetch_blank;
    color_t                 cell_fore;
    color_t                 cell_back;
    logic [FONT_ADDR_W-1:0] font_addr_hold;
    logic [FONT_ADDR_W-1:0] font_addr_live;
    logic [GLYPH_W-1:0]     next_bits;
    color_t                 next_fore;
    color_t                 next_back;

    logic                   line_active;
    logic                   pixel_blank;
    logic                   cell_start;
    logic                   fetch_start;
    logic                   cell_readable;

    // After reset nothing is shown until an eof has been seen and then a sol.
    assign line_active    = vis_i && line_armed;
    assign pixel_blank    = !line_active;
    assign cell_start     = line_active && (px == '0);
    assign fetch_start    = (sol_i && (frame_armed || eof_i)) || cell_start;
    assign cell_readable  = (col < COL_END) && (text_row < ROW_END);
    assign font_addr_live = {(fetch_blank ? 8'h00 : rd_data_i[CHAR_LSB +: CHAR_BITS]), scanline};
    assign rd_addr_o      = line_base + disp_addr_t'(col);
    assign pix_valid_o    = pix_valid;

    // Fetch FSM state register.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state <= F_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Fetch FSM sequencing plus the RAM strobe and font address it drives.
    always_comb begin
        state_next  = state;
        rd_en_o     = 1'b0;
        font_addr_o = font_addr_hold;
        case (state)
            F_IDLE: begin
                if (fetch_start) begin
                    state_next = F_RD_CELL;
                end
            end
            F_RD_CELL: begin
                rd_en_o    = cell_readable;
                state_next = F_RD_FONT;
            end
            F_RD_FONT: begin
                font_addr_o = font_addr_live;
                state_next  = F_LATCH;
            end
            F_LATCH: begin
                state_next = F_IDLE;
            end
            default: begin
                state_next = F_IDLE;
            end
        endcase
    end

    // Cell capture and staging of the next cell for the glyph shifter.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            col            <= '0;
            fetch_blank    <= 1'b0;
            cell_fore      <= '0;
            cell_back      <= '0;
            font_addr_hold <= '0;
            next_bits      <= '0;
            next_fore      <= '0;
            next_back      <= '0;
        end else begin
            case (state)
                F_RD_CELL: begin
                    fetch_blank <= !cell_readable;
                end
                F_RD_FONT: begin
                    cell_fore      <= fetch_blank ? '0 : rd_data_i[FORE_LSB +: COLOR_W];
                    cell_back      <= fetch_blank ? '0 : rd_data_i[BACK_LSB +: COLOR_W];
                    font_addr_hold <= font_addr_live;
                end
                F_LATCH: begin
                    next_bits <= fetch_blank ? '0 : font_data_i;
                    next_fore <= cell_fore;
                    next_back <= cell_back;
                    if (col != '1) begin
                        col <= col + 8'd1;
                    end
                end
                default: begin
                end
            endcase
            if (sol_i) begin
                col <= '0;
            end
        end
    end

    // Frame position: eof clears it (taking priority), the end of each line advances it.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            scanline    <= '0;
            text_row    <= '0;
            line_base   <= '0;
            frame_armed <= 1'b0;
            line_armed  <= 1'b0;
        end else begin
            if (eof_i) begin
                scanline    <= '0;
                text_row    <= '0;
                line_base   <= '0;
                frame_armed <= 1'b1;
            end else if (vis_prev && !vis_i) begin
                if (scanline == SL_LAST) begin
                    scanline  <= '0;
                    line_base <= line_base + disp_addr_t'(COLS);
                    if (text_row != '1) begin
                        text_row <= text_row + 8'd1;
                    end
                end else begin
                    scanline <= scanline + SL_W'(1);
                end
            end
            if (sol_i) begin
                line_armed <= frame_armed || eof_i;
            end
        end
    end

    // Pixel counter within a cell and one-cycle valid alignment.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            px        <= '0;
            vis_prev  <= 1'b0;
            pix_valid <= 1'b0;
        end else begin
            vis_prev  <= vis_i;
            pix_valid <= line_active;
            if (!line_active || (px == PX_LAST)) begin
                px <= '0;
            end else begin
                px <= px + PX_W'(1);
            end
        end
    end

    video_glyph_shift u_glyph (
        .clk       (clk),
        .reset     (reset_i),
        .blank     (pixel_blank),
        .load      (cell_start),
        .load_bits (next_bits),
        .load_fore (next_fore),
        .load_back (next_back),
        .color     (color_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_video_text_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_text_fetch
// Brief    : Scoreboard bench for video_text_fetch with RAM/ROM models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_text_fetch;
    import video_text_fetch_pkg::*;

    logic             clk = 1'b0;
    logic             reset_i;
    logic             eof_i;
    logic             sol_i;
    logic             vis_i;
    logic             rd_en_o;
    disp_addr_t       rd_addr_o;
    disp_data_t       rd_data_i;
    logic [11:0]      font_addr_o;
    logic [7:0]       font_data_i;
    color_t           color_o;
    logic             pix_valid_o;

    logic [15:0]      disp_mem [0:4095];
    logic [7:0]       font_mem [0:4095];
    logic [3:0]       hand_cell0 [0:7] = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd1, 4'd1, 4'd1};

    typedef struct { logic [3:0] color; int cyc; } pix_exp_t;
    typedef struct { logic [11:0] addr; int latest; } rd_exp_t;

    pix_exp_t pix_q[$];
    rd_exp_t  rd_q[$];

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;
    int line_idx = 0;
    int stray = 0;
    bit mon_en = 1'b0;
    bit stray_en = 1'b0;

    video_text_fetch dut (
        .clk         (clk),
        .reset_i     (reset_i),
        .eof_i       (eof_i),
        .sol_i       (sol_i),
        .vis_i       (vis_i),
        .rd_en_o     (rd_en_o),
        .rd_addr_o   (rd_addr_o),
        .rd_data_i   (rd_data_i),
        .font_addr_o (font_addr_o),
        .font_data_i (font_data_i),
        .color_o     (color_o),
        .pix_valid_o (pix_valid_o)
    );

    always #5 clk = ~clk;

    // Cycle counter and synchronous memory models
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en_o) rd_data_i <= disp_mem[rd_addr_o];
        font_data_i <= font_mem[font_addr_o];
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_rd_en"},     int'(rd_en_o),     0);
        check({tag, "_rd_addr"},   int'(rd_addr_o),   0);
        check({tag, "_font_addr"}, int'(font_addr_o), 0);
        check({tag, "_color"},     int'(color_o),     0);
        check({tag, "_pix_valid"}, int'(pix_valid_o), 0);
    endtask

    // Expected pixels and reads for the current line, from the bench memories
    task automatic push_line(input int ncells, input int vis_cyc);
        int          sl;
        int          row;
        logic [15:0] w;
        logic [7:0]  bits;
        logic [3:0]  c;
        sl  = line_idx % 16;
        row = line_idx / 16;
        for (int k = 0; k < ncells; k++) begin
            w    = 16'h0;
            bits = 8'h0;
            if (row < 30 && k < 80) begin
                w    = disp_mem[12'(row * 80 + k)];
                bits = font_mem[{w[7:0], 4'(sl)}];
            end
            for (int p = 0; p < 8; p++) begin
                c = bits[7 - p] ? w[11:8] : w[15:12];
                if (line_idx == 0 && k == 0) c = hand_cell0[p];
                pix_q.push_back('{color: c, cyc: vis_cyc + 1 + 8 * k + p});
            end
        end
        if (row < 30) begin
            for (int k = 0; k <= ncells && k < 80; k++)
                rd_q.push_back('{addr: 12'(row * 80 + k), latest: vis_cyc + 8 * k - 4});
        end
    endtask

    task automatic pulse_eof();
        @(posedge clk); #1; eof_i = 1'b1;
        @(posedge clk); #1; eof_i = 1'b0;
        line_idx = 0;
    endtask

    // sol, 8 cycles later vis for ncells*8 cycles, then horizontal blanking
    task automatic run_line(input int ncells, input bit expect_out);
        int vis_cyc;
        @(posedge clk); #1;
        sol_i   = 1'b1;
        vis_cyc = cyc + 8;
        if (expect_out) push_line(ncells, vis_cyc);
        @(posedge clk); #1; sol_i = 1'b0;
        repeat (7) @(posedge clk);
        #1; vis_i = 1'b1;
        repeat (8 * ncells) @(posedge clk);
        #1; vis_i = 1'b0;
        repeat (6) @(posedge clk);
        line_idx++;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a pixel or a read
    initial begin : monitor
        pix_exp_t pe;
        rd_exp_t  re;
        forever begin
            @(negedge clk);
            if (mon_en && pix_valid_o) begin
                n_checks++;
                if (pix_q.size() == 0) begin
                    $display("FAIL pixel: got color %0d at cycle %0d, expected no pixel", color_o, cyc);
                end else begin
                    pe = pix_q.pop_front();
                    if (color_o === pe.color && cyc == pe.cyc) n_pass++;
                    else $display("FAIL pixel: got color %0d at cycle %0d, expected color %0d at cycle %0d",
                                  color_o, cyc, pe.color, pe.cyc);
                end
            end
            if (mon_en && rd_en_o) begin
                n_checks++;
                if (rd_q.size() == 0) begin
                    $display("FAIL read: got addr %0d at cycle %0d, expected no read", rd_addr_o, cyc);
                end else begin
                    re = rd_q.pop_front();
                    if (rd_addr_o === re.addr && cyc <= re.latest) n_pass++;
                    else $display("FAIL read: got addr %0d at cycle %0d, expected addr %0d by cycle %0d",
                                  rd_addr_o, cyc, re.addr, re.latest);
                end
            end
            if (stray_en && (rd_en_o || pix_valid_o)) stray++;
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL timeout: got no end of run, expected completion");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1);
    end

    initial begin : main
        for (int a = 0; a < 4096; a++) begin
            disp_mem[a] = {2'b00, 2'(a), 1'b1, 3'(a), 8'(a * 7 + 3)};
            font_mem[a] = 8'((a * 37) ^ (a >> 3));
        end
        disp_mem[0]      = 16'h1241;
        font_mem[12'h410] = 8'h18;

        reset_i = 1'b1;
        eof_i   = 1'b0;
        sol_i   = 1'b0;
        vis_i   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        @(posedge clk); #1; reset_i = 1'b0;

        // Frame: full line 0, short lines, full lines 16 and 17 (17 overruns by one cell)
        mon_en = 1'b1;
        pulse_eof();
        run_line(80, 1'b1);
        check("line0_reads_left", rd_q.size(), 0);
        check("line0_pixels_left", pix_q.size(), 0);
        while (line_idx < 16) run_line(1, 1'b1);
        @(negedge clk);
        check("font_scanline15", int'(font_addr_o[3:0]), 15);
        run_line(80, 1'b1);
        @(negedge clk);
        check("font_scanline0", int'(font_addr_o[3:0]), 0);
        run_line(81, 1'b1);
        check("line17_reads_left", rd_q.size(), 0);
        check("line17_pixels_left", pix_q.size(), 0);

        // Remaining text rows, then two lines below the last text row
        while (line_idx < 480) run_line(1, 1'b1);
        run_line(4, 1'b1);
        run_line(4, 1'b1);
        check("rows_end_reads_left", rd_q.size(), 0);
        check("rows_end_pixels_left", pix_q.size(), 0);

        // Reset in the middle of a line at px=3
        mon_en = 1'b0;
        pulse_eof();
        @(posedge clk); #1; sol_i = 1'b1;
        @(posedge clk); #1; sol_i = 1'b0;
        repeat (7) @(posedge clk);
        #1; vis_i = 1'b1;
        repeat (3) @(posedge clk);
        #1; reset_i = 1'b1;
        @(posedge clk); #1; reset_i = 1'b0;
        stray_en = 1'b1;
        @(negedge clk);
        check_idle("midreset");
        repeat (12) @(posedge clk);
        #1; vis_i = 1'b0;
        repeat (6) @(posedge clk);
        line_idx = 0;
        run_line(2, 1'b0);
        stray_en = 1'b0;
        check("blank_until_eof", stray, 0);

        // Clean line after eof + sol
        mon_en = 1'b1;
        pulse_eof();
        run_line(80, 1'b1);
        check("final_reads_left", rd_q.size(), 0);
        check("final_pixels_left", pix_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
